ph_ram_arbiter: RTL and testbench
=================================

# ph_ram_arbiter

Two-master arbiter that shares the single physical RAM port (phRam* bus) between the MemoryController and a second requester, such as a UART boot loader or debug DMA. It grants one access at a time with round-robin priority and drives the RAM for a fixed latency. It returns read data with a one-cycle acknowledge to the granted master. It sits between the masters and the board RAM inside CPU.

## Interface
Parameters:
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width.
- `LATENCY`, default 1, RAM cycles per access with phRequest held high; must be 1..15.

Ports (x = 0, 1):
- `clk`  in  1  the single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `mxRequest`  in  1  access request from master x; held until `mxAck`.
- `mxAddress`  in  ADDR_W  word address; stable while requesting.
- `mxWriteData`  in  DATA_W  write data.
- `mxWriteEnable`  in  1  1 = write, 0 = read.
- `mxReadData`  out  DATA_W  read result; valid in the `mxAck` cycle, then held.
- `mxAck`  out  1  one-cycle completion pulse.
- `phRequest`  out  1  RAM access strobe.
- `phRamAddress`  out  ADDR_W  RAM address.
- `phRamWrite`  out  DATA_W  RAM write data.
- `phWriteEnable`  out  1  RAM write strobe.
- `phRamRead`  in  DATA_W  RAM read data; valid in the last cycle of the access.

## Operation
The arbiter is a three-state FSM: IDLE → ACCESS → RESP → IDLE.

- **IDLE**
  - Requests are sampled only in this state.
  - If only one `mxRequest` is high, that master is granted.
  - If both are high, the master other than `lastServed` is granted.
  - On grant, latch the master's address, write data and write enable plus the grant index; load `cnt = LATENCY-1`; go to ACCESS.
- **ACCESS**
  - phRequest = 1; phRamAddress, phRamWrite and phWriteEnable come from the latched registers.
  - `cnt` decrements each cycle.
  - When `cnt == 0`: for a read, capture phRamRead into the granted master's read-data register. Then go to RESP.
- **RESP**
  - Pulse the granted master's ack for one cycle.
  - Set `lastServed` to the grant index; go to IDLE.
- **Idle bus outputs:** outside ACCESS, phRequest, phWriteEnable, phRamAddress and phRamWrite are 0.
- **Read-data registers:** a write never updates `mxReadData`; each master's register holds its last read value.
- **Master rule:** a master must hold its request and request fields stable until its ack. A request still high in the IDLE cycle after the ack is treated as a new request.
- **Reset (asynchronous, active-low):**
  - All outputs go to 0, the state goes to IDLE, `cnt` clears, and `lastServed` = 1, so m0 wins the first tie.
  - Reset asserted mid-ACCESS drops phRequest immediately and no ack is issued.
  - Masters still requesting after reset deasserts are re-arbitrated from scratch.

## Timing
- **Latency:** if a request is sampled in IDLE at cycle T, phRequest is high for cycles T+1 … T+LATENCY and the ack is at cycle T+LATENCY+1.
- **Throughput:** one access per LATENCY+2 cycles. The IDLE cycle is always present; there is no RESP→ACCESS bypass.
- **Simultaneous requests:** alternate strictly. Worst-case wait for a requesting master is one foreign access, i.e. LATENCY+2 cycles.
- **Request arriving during ACCESS/RESP:** waits for the next IDLE.
- **Output registering:** all outputs are registered. The ack and read data change only on clock edges, or on asynchronous reset.

## Structure
- **Shared package `ph_arb_pkg`:**
  - state enum `arb_state_t` with values ARB_IDLE, ARB_ACCESS, ARB_RESP;
  - master index constants `ARB_M0 = 0` and `ARB_M1 = 1`.
- **Module:** a single module, `ph_ram_arbiter`.
- **Sub-modules:** none needed; the round-robin pick is a two-line expression.
- **Counter:** `cnt` is 4 bits wide, sized from the LATENCY maximum of 15.

## Test plan
1. Reset, then a single read. Preload the RAM model with `0x100 = 0xDEADBEEF`; m0 reads `0x100` with LATENCY = 1. Expect phRequest high for one cycle, m0Ack two cycles after the request is sampled, and m0ReadData = `0xDEADBEEF`.
2. Write then read. m1 writes `0x55AA1234` to `0x20`, then reads `0x20`. Expect phWriteEnable high only during the write's ACCESS. The read returns `0x55AA1234`, and m1ReadData is unchanged at the write's ack.
3. Contention. m0 and m1 request continuously from the same cycle after reset. Expect grants in the order m0, m1, m0, m1, with acks 3 cycles apart (LATENCY = 1).
4. LATENCY = 4. A read is sampled at T. Expect phRequest high for T+1 … T+4, the read captured at T+4, and the ack at T+5.
5. Reset mid-access. With LATENCY = 4, assert reset during the second ACCESS cycle. Expect phRequest = 0 immediately and no ack. After release, the still-pending m0 request completes normally.
6. Late request. m1 raises its request during m0's ACCESS. Expect m1 to be granted in the IDLE after m0's ack, with no glitch on phRamAddress.

Source files
------------

// File: rtl/ph_arb_pkg.sv
// Shared types and constants for the two-master physical RAM arbiter.
package ph_arb_pkg;

  // Arbiter FSM states: one grant cycle, LATENCY bus cycles, one ack cycle.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  // Master indices, also used as the grant / last-served encoding.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Access counter width, sized for the largest supported LATENCY (15).
  localparam int CNT_W       = 4;
  localparam int LATENCY_MAX = 15;

  // Round-robin pick: on a tie the master that was not served last wins,
  // otherwise whichever master is requesting.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_served);
    if (req0 && req1) return ~last_served;
    return req1 ? ARB_M1 : ARB_M0;
  endfunction

endpackage

// File: rtl/ph_ram_arbiter.sv
// Two-master round-robin arbiter in front of the single physical RAM port.
// One access at a time: IDLE (arbitrate) -> ACCESS (LATENCY cycles on the
// RAM bus) -> RESP (one-cycle ack) -> IDLE. Every output is a flop.
module ph_ram_arbiter
  import ph_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1    // RAM cycles per access, 1..LATENCY_MAX
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0Request,
  input  logic [ADDR_W-1:0] m0Address,
  input  logic [DATA_W-1:0] m0WriteData,
  input  logic              m0WriteEnable,
  output logic [DATA_W-1:0] m0ReadData,
  output logic              m0Ack,

  input  logic              m1Request,
  input  logic [ADDR_W-1:0] m1Address,
  input  logic [DATA_W-1:0] m1WriteData,
  input  logic              m1WriteEnable,
  output logic [DATA_W-1:0] m1ReadData,
  output logic              m1Ack,

  output logic              phRequest,
  output logic [ADDR_W-1:0] phRamAddress,
  output logic [DATA_W-1:0] phRamWrite,
  output logic              phWriteEnable,
  input  logic [DATA_W-1:0] phRamRead
);

  // Counter preload: ACCESS lasts cnt+1 cycles, ending when cnt reaches 0.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  // Current state and latched request.
  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;

  // Next values of the registered outputs.
  logic              ph_req_d;
  logic [ADDR_W-1:0] ph_addr_d;
  logic [DATA_W-1:0] ph_wdata_d;
  logic              ph_we_d;
  logic              ack0_d, ack1_d;
  logic [DATA_W-1:0] rd0_d, rd1_d;

  // Next-state logic plus next values of every registered output.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rd0_d      = m0ReadData;
    rd1_d      = m1ReadData;
    ph_req_d   = 1'b0;
    ph_addr_d  = '0;
    ph_wdata_d = '0;
    ph_we_d    = 1'b0;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (m0Request || m1Request) begin
          grant_d = rr_pick(m0Request, m1Request, last_q);
          addr_d  = (grant_d == ARB_M1) ? m1Address     : m0Address;
          wdata_d = (grant_d == ARB_M1) ? m1WriteData   : m0WriteData;
          we_d    = (grant_d == ARB_M1) ? m1WriteEnable : m0WriteEnable;
          cnt_d   = LAT_LOAD;
          state_d = ARB_ACCESS;
        end
      end

      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          // Last bus cycle: RAM read data is valid now.
          if (!we_q) begin
            if (grant_q == ARB_M1) rd1_d = phRamRead;
            else                   rd0_d = phRamRead;
          end
          state_d = ARB_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ARB_RESP: begin
        last_d  = grant_q;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase

    // Bus outputs are registered, so they follow the state being entered;
    // outside ACCESS the bus is driven to all zeros.
    if (state_d == ARB_ACCESS) begin
      ph_req_d   = 1'b1;
      ph_addr_d  = addr_d;
      ph_wdata_d = wdata_d;
      ph_we_d    = we_d;
    end

    // The ack flop is high exactly for the RESP cycle.
    if (state_d == ARB_RESP) begin
      ack0_d = (grant_d == ARB_M0);
      ack1_d = (grant_d == ARB_M1);
    end
  end

  // State, latched request and output registers; reset idles the bus at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      cnt_q         <= '0;
      grant_q       <= ARB_M0;
      last_q        <= ARB_M1;    // m0 wins the first tie
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      m0ReadData    <= '0;
      m1ReadData    <= '0;
      m0Ack         <= 1'b0;
      m1Ack         <= 1'b0;
      phRequest     <= 1'b0;
      phRamAddress  <= '0;
      phRamWrite    <= '0;
      phWriteEnable <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      m0ReadData    <= rd0_d;
      m1ReadData    <= rd1_d;
      m0Ack         <= ack0_d;
      m1Ack         <= ack1_d;
      phRequest     <= ph_req_d;
      phRamAddress  <= ph_addr_d;
      phRamWrite    <= ph_wdata_d;
      phWriteEnable <= ph_we_d;
    end
  end

endmodule

// File: tb/tb_ph_ram_arbiter.sv
// Self-checking bench for ph_ram_arbiter: one instance with LATENCY=1 and one
// with LATENCY=4, each with its own RAM model. Expected acks and read data go
// into a scoreboard queue when a request is raised and are compared whenever
// an ack appears.
module tb_ph_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } mreq_t;

  typedef struct {
    int            inst;
    int            m;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n    [2];
  mreq_t         mi       [2][2];
  logic [DW-1:0] rd       [2][2];
  logic          ack      [2][2];
  logic          ph_req   [2];
  logic [AW-1:0] ph_addr  [2];
  logic [DW-1:0] ph_wdata [2];
  logic          ph_we    [2];
  logic [DW-1:0] ph_rd    [2];
  logic [DW-1:0] mem      [2][1024];

  logic          bd_valid;
  int            bd_inst;
  logic [9:0]    bd_addr;
  logic [DW-1:0] bd_data;

  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t sbq[$];

  ph_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(rst_n[0]),
    .m0Request(mi[0][0].req), .m0Address(mi[0][0].addr),
    .m0WriteData(mi[0][0].wdata), .m0WriteEnable(mi[0][0].we),
    .m0ReadData(rd[0][0]), .m0Ack(ack[0][0]),
    .m1Request(mi[0][1].req), .m1Address(mi[0][1].addr),
    .m1WriteData(mi[0][1].wdata), .m1WriteEnable(mi[0][1].we),
    .m1ReadData(rd[0][1]), .m1Ack(ack[0][1]),
    .phRequest(ph_req[0]), .phRamAddress(ph_addr[0]),
    .phRamWrite(ph_wdata[0]), .phWriteEnable(ph_we[0]),
    .phRamRead(ph_rd[0])
  );

  ph_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(4)) u_lat4 (
    .clk(clk), .reset(rst_n[1]),
    .m0Request(mi[1][0].req), .m0Address(mi[1][0].addr),
    .m0WriteData(mi[1][0].wdata), .m0WriteEnable(mi[1][0].we),
    .m0ReadData(rd[1][0]), .m0Ack(ack[1][0]),
    .m1Request(mi[1][1].req), .m1Address(mi[1][1].addr),
    .m1WriteData(mi[1][1].wdata), .m1WriteEnable(mi[1][1].we),
    .m1ReadData(rd[1][1]), .m1Ack(ack[1][1]),
    .phRequest(ph_req[1]), .phRamAddress(ph_addr[1]),
    .phRamWrite(ph_wdata[1]), .phWriteEnable(ph_we[1]),
    .phRamRead(ph_rd[1])
  );

  // RAM models: combinational read, write on the clock edge, plus a backdoor
  // port for preloading and changing contents from the stimulus tasks.
  assign ph_rd[0] = mem[0][ph_addr[0][9:0]];
  assign ph_rd[1] = mem[1][ph_addr[1][9:0]];

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    for (int i = 0; i < 2; i++)
      if (ph_req[i] && ph_we[i]) mem[i][ph_addr[i][9:0]] <= ph_wdata[i];
    if (bd_valid) mem[bd_inst][bd_addr] <= bd_data;
  end

  // Scoreboard: every ack must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++)
      for (int m = 0; m < 2; m++)
        if (ack[i][m] === 1'b1) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack: got ack inst%0d m%0d data %h, expected no ack",
                     i, m, rd[i][m]);
          end else begin
            e = sbq.pop_front();
            if (e.inst != i || e.m != m || rd[i][m] !== e.data) begin
              errors++;
              $display("FAIL ack_scoreboard: got inst%0d m%0d data %h, expected inst%0d m%0d data %h",
                       i, m, rd[i][m], e.inst, e.m, e.data);
            end
          end
        end
  end

  task automatic push_exp(input int inst, input int m, input logic [DW-1:0] data);
    exp_t e;
    e.inst = inst;
    e.m    = m;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic set_req(input int inst, input int m, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic we);
    mi[inst][m].req   = 1'b1;
    mi[inst][m].addr  = addr;
    mi[inst][m].wdata = wdata;
    mi[inst][m].we    = we;
  endtask

  task automatic bd_write(input int inst, input logic [9:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    bd_valid = 1'b1;
    bd_inst  = inst;
    bd_addr  = addr;
    bd_data  = data;
    @(negedge clk);
    bd_valid = 1'b0;
  endtask

  task automatic do_reset(input int inst);
    @(negedge clk);
    rst_n[inst] = 1'b0;
    mi[inst][0] = '0;
    mi[inst][1] = '0;
    repeat (2) @(negedge clk);
    rst_n[inst] = 1'b1;
  endtask

  // One access from an otherwise idle arbiter: checks the bus every cycle,
  // the ack cycle and the number of phRequest cycles. With swap set, the RAM
  // word changes so that only the last ACCESS cycle sees swap_val.
  task automatic access(input int inst, input int m, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic we,
                        input logic [DW-1:0] exp_rd, input int lat,
                        input bit swap, input logic [DW-1:0] swap_val);
    int s, ph_cnt;
    bit done;
    @(negedge clk);
    set_req(inst, m, addr, wdata, we);
    push_exp(inst, m, exp_rd);
    s = edge_cnt;
    ph_cnt = 0;
    done = 0;
    for (int k = 0; k < lat + 10 && !done; k++) begin
      @(negedge clk);
      bd_valid = 1'b0;
      if (swap && edge_cnt == s + lat - 1) begin
        bd_valid = 1'b1;
        bd_inst  = inst;
        bd_addr  = addr[9:0];
        bd_data  = swap_val;
      end
      checks++;
      if (ph_req[inst]) begin
        ph_cnt++;
        if (ph_addr[inst] !== addr || ph_we[inst] !== we ||
            (we && ph_wdata[inst] !== wdata) || edge_cnt < s + 1 || edge_cnt > s + lat) begin
          errors++;
          $display("FAIL bus_access: got addr %h we %b wdata %h at edge %0d, expected addr %h we %b in edges %0d..%0d",
                   ph_addr[inst], ph_we[inst], ph_wdata[inst], edge_cnt, addr, we, s + 1, s + lat);
        end
      end else if (ph_addr[inst] !== '0 || ph_wdata[inst] !== '0 || ph_we[inst] !== 1'b0) begin
        errors++;
        $display("FAIL bus_idle: got addr %h wdata %h we %b, expected all zero",
                 ph_addr[inst], ph_wdata[inst], ph_we[inst]);
      end
      if (ack[inst][m] === 1'b1) begin
        done = 1;
        checks++;
        if (edge_cnt != s + lat + 1 || ph_cnt != lat) begin
          errors++;
          $display("FAIL ack_timing: got ack at edge %0d after %0d bus cycles, expected edge %0d after %0d",
                   edge_cnt, ph_cnt, s + lat + 1, lat);
        end
        mi[inst][m].req = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack inst%0d m%0d, expected one within %0d cycles", inst, m, lat + 10);
      mi[inst][m].req = 1'b0;
      if (sbq.size() > 0) void'(sbq.pop_back());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ph_req[i] !== 1'b0 || ph_addr[i] !== '0 || ph_wdata[i] !== '0 || ph_we[i] !== 1'b0 ||
          ack[i][0] !== 1'b0 || ack[i][1] !== 1'b0 || rd[i][0] !== '0 || rd[i][1] !== '0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got req %b addr %h we %b ack %b%b rd %h %h, expected all zero",
                 i, ph_req[i], ph_addr[i], ph_we[i], ack[i][0], ack[i][1], rd[i][0], rd[i][1]);
      end
    end
  endtask

  task automatic test_single_read();
    bd_write(0, 10'h100, 32'hDEADBEEF);
    access(0, 0, 32'h100, '0, 1'b0, 32'hDEADBEEF, 1, 1'b0, '0);
  endtask

  task automatic test_write_read();
    // Old RAM contents differ from the held read data, so a write that
    // wrongly captured phRamRead would show up at its ack.
    bd_write(0, 10'h020, 32'h0BADBAD0);
    access(0, 1, 32'h20, 32'h55AA1234, 1'b1, 32'h0, 1, 1'b0, '0);
    access(0, 1, 32'h20, '0, 1'b0, 32'h55AA1234, 1, 1'b0, '0);
  endtask

  task automatic test_contention();
    int s, n, prev;
    do_reset(0);
    @(negedge clk);
    set_req(0, 0, 32'h100, '0, 1'b0);
    set_req(0, 1, 32'h20, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, 0, 32'hDEADBEEF);
      else            push_exp(0, 1, 32'h55AA1234);
    end
    s = edge_cnt;
    n = 0;
    prev = s - 1;   // first ack is due 3 edges after this, at s+2
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      if (ack[0][0] === 1'b1 || ack[0][1] === 1'b1) begin
        checks++;
        if (ack[0][n % 2] !== 1'b1 || edge_cnt != prev + 3) begin
          errors++;
          $display("FAIL contention_order ack %0d: got ack m0=%b m1=%b at edge %0d, expected m%0d at edge %0d",
                   n, ack[0][0], ack[0][1], edge_cnt, n % 2, prev + 3);
        end
        prev = edge_cnt;
        n++;
      end
    end
    mi[0][0].req = 1'b0;
    mi[0][1].req = 1'b0;
    if (n < 4) begin
      checks++;
      errors++;
      $display("FAIL contention_timeout: got %0d acks, expected 4", n);
      while (sbq.size() > 0) void'(sbq.pop_back());
    end
  endtask

  task automatic test_latency4();
    do_reset(1);
    bd_write(1, 10'h040, 32'h11111111);
    access(1, 0, 32'h40, '0, 1'b0, 32'hCAFEF00D, 4, 1'b1, 32'hCAFEF00D);
  endtask

  task automatic test_reset_mid_access();
    int s;
    bit done;
    @(negedge clk);
    set_req(1, 0, 32'h40, '0, 1'b0);
    repeat (2) @(negedge clk);   // second ACCESS cycle
    checks++;
    if (ph_req[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_active: got phRequest %b, expected 1", ph_req[1]);
    end
    rst_n[1] = 1'b0;
    #1;
    checks++;
    if (ph_req[1] !== 1'b0 || ph_addr[1] !== '0) begin
      errors++;
      $display("FAIL mid_access_reset: got phRequest %b addr %h, expected 0 and 0", ph_req[1], ph_addr[1]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ack[1][0] !== 1'b0 || ph_req[1] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got ack %b phRequest %b, expected 0 and 0", ack[1][0], ph_req[1]);
      end
    end
    rst_n[1] = 1'b1;             // m0 is still requesting
    push_exp(1, 0, 32'hCAFEF00D);
    s = edge_cnt;
    done = 0;
    for (int k = 0; k < 15 && !done; k++) begin
      @(negedge clk);
      if (ack[1][0] === 1'b1) begin
        done = 1;
        checks++;
        if (edge_cnt != s + 5) begin
          errors++;
          $display("FAIL post_reset_ack: got edge %0d, expected %0d", edge_cnt, s + 5);
        end
        mi[1][0].req = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL post_reset_timeout: got no ack, expected ack at edge %0d", s + 5);
      mi[1][0].req = 1'b0;
      if (sbq.size() > 0) void'(sbq.pop_back());
    end
  endtask

  task automatic test_late_request();
    int s;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
    bd_write(0, 10'h300, 32'h13572468);
    @(negedge clk);
    set_req(0, 0, 32'h100, '0, 1'b0);
    push_exp(0, 0, 32'hDEADBEEF);
    s = edge_cnt;
    while (edge_cnt < s + 6) begin
      @(negedge clk);
      if (edge_cnt == s + 1) begin
        set_req(0, 1, 32'h300, '0, 1'b0);
        push_exp(0, 1, 32'h13572468);
      end
      exp_req  = (edge_cnt == s + 1) || (edge_cnt == s + 4);
      exp_addr = (edge_cnt == s + 1) ? 32'h100 : (edge_cnt == s + 4) ? 32'h300 : 32'h0;
      checks++;
      if (ph_req[0] !== exp_req || ph_addr[0] !== exp_addr ||
          ack[0][0] !== (edge_cnt == s + 2) || ack[0][1] !== (edge_cnt == s + 5)) begin
        errors++;
        $display("FAIL late_request edge %0d: got req %b addr %h ack %b%b, expected req %b addr %h ack %b%b",
                 edge_cnt - s, ph_req[0], ph_addr[0], ack[0][0], ack[0][1],
                 exp_req, exp_addr, edge_cnt == s + 2, edge_cnt == s + 5);
      end
      if (ack[0][0] === 1'b1) mi[0][0].req = 1'b0;
      if (ack[0][1] === 1'b1) mi[0][1].req = 1'b0;
    end
    mi[0][0].req = 1'b0;
    mi[0][1].req = 1'b0;
  endtask

  initial begin
    bd_valid = 1'b0;
    bd_inst  = 0;
    bd_addr  = '0;
    bd_data  = '0;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      mi[i][0] = '0;
      mi[i][1] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_latency4();
    test_reset_mid_access();
    test_late_request();

    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending completions, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
